// File: rtl/core_dispatcher_pkg.sv
// Shared constants for the packet-core dispatcher: default core count,
// derived index/count widths and the verdict encoding.
package core_dispatcher_pkg;

   localparam int N_CORES_DEF   = 4;
   localparam int ID_WIDTH_DEF  = $clog2(N_CORES_DEF);
   localparam int CNT_WIDTH_DEF = ID_WIDTH_DEF + 1;

   localparam logic VRD_ACC = 1'b1;
   localparam logic VRD_REJ = 1'b0;

endpackage

// File: rtl/core_dispatcher_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr,
// wrapping modulo N (N must be a power of two).
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   output logic [N-1:0] o_gnt,
   output logic [W-1:0] o_idx,
   output logic         o_any
);

   // w_rot[k] is the request k positions past the pointer
   logic [N-1:0] w_rot;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_rot
         logic [W-1:0] w_src;
         assign w_src     = i_ptr + W'(gi);
         assign w_rot[gi] = i_req[w_src];
      end
   endgenerate

   always_comb begin
      o_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            o_idx = i_ptr + W'(k);
         end
      end
      o_any = |w_rot;
      o_gnt = o_any ? ({{(N-1){1'b0}}, 1'b1} << o_idx) : '0;
   end

endmodule

// File: rtl/core_dispatcher.sv
// Distributes packets over N_CORES filter cores and retires their verdicts in
// dispatch order. CORE_DISPATCHER_STATS_EN adds accept/reject counters.
module core_dispatcher
   import core_dispatcher_pkg::*;
#(
   parameter int N_CORES   = N_CORES_DEF,
   parameter int ID_WIDTH  = $clog2(N_CORES),
   parameter int CNT_WIDTH = ID_WIDTH + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pkt_req,
   output logic                 pkt_gnt,
   output logic [ID_WIDTH-1:0]  pkt_core,
   input  logic [N_CORES-1:0]   core_idle,
   output logic [N_CORES-1:0]   core_start,
   input  logic [N_CORES-1:0]   core_acc,
   input  logic [N_CORES-1:0]   core_rej,
   output logic [N_CORES-1:0]   core_done_ack,
   output logic                 vrd_vld,
   input  logic                 vrd_rdy,
   output logic                 vrd_acc,
   output logic [ID_WIDTH-1:0]  vrd_core,
`ifdef CORE_DISPATCHER_STATS_EN
   input  logic                 stats_clr,
   output logic [31:0]          acc_cnt,
   output logic [31:0]          rej_cnt,
`endif
   output logic [CNT_WIDTH-1:0] inflight
);

   logic [ID_WIDTH-1:0]  r_fifo [N_CORES];
   logic [ID_WIDTH:0]    r_wr_ptr;
   logic [ID_WIDTH:0]    r_rd_ptr;
   logic [CNT_WIDTH-1:0] r_inflight;
   logic [N_CORES-1:0]   r_busy;
   logic [ID_WIDTH-1:0]  r_rr_ptr;
   logic                 r_rst_q;

   logic [N_CORES-1:0]   w_eligible;
   logic [N_CORES-1:0]   w_arb_gnt;
   logic [ID_WIDTH-1:0]  w_arb_idx;
   logic                 w_arb_any;
   logic                 w_gnt;
   logic                 w_empty;
   logic [ID_WIDTH-1:0]  w_head;
   logic                 w_head_acc;
   logic                 w_head_rej;
   logic                 w_vld;
   logic                 w_fire;

   assign w_eligible = core_idle & ~r_busy;

   rr_arbiter #(
      .N (N_CORES),
      .W (ID_WIDTH)
   ) u_arb (
      .i_req (w_eligible),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_arb_gnt),
      .o_idx (w_arb_idx),
      .o_any (w_arb_any)
   );

   // r_rst_q keeps every output quiet for the first cycle out of reset
   assign w_gnt    = pkt_req & w_arb_any & ~rst & ~r_rst_q;
   assign w_empty  = (r_inflight == '0);
   assign w_head   = r_fifo[r_rd_ptr[ID_WIDTH-1:0]];
   assign w_head_acc = core_acc[w_head];
   assign w_head_rej = core_rej[w_head];
   assign w_vld    = ~w_empty & (w_head_acc | w_head_rej) & ~rst & ~r_rst_q;
   assign w_fire   = w_vld & vrd_rdy;

   assign pkt_gnt    = w_gnt;
   assign pkt_core   = w_gnt ? w_arb_idx : '0;
   assign core_start = w_gnt ? w_arb_gnt : '0;
   assign vrd_vld    = w_vld;
   assign vrd_acc    = w_vld & w_head_acc & ~w_head_rej;
   assign vrd_core   = w_vld ? w_head : '0;
   assign inflight   = rst ? '0 : r_inflight;

   generate
      for (genvar gi = 0; gi < N_CORES; gi++) begin : g_ack
         assign core_done_ack[gi] = w_fire & (w_head == ID_WIDTH'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      r_rst_q <= rst;
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_inflight <= '0;
         r_busy     <= '0;
         r_rr_ptr   <= '0;
      end else begin
         // granted core is never busy and the retired one always is, so no overlap
         r_busy     <= (r_busy | core_start) & ~core_done_ack;
         r_inflight <= r_inflight + CNT_WIDTH'(w_gnt) - CNT_WIDTH'(w_fire);
         if (w_gnt) begin
            r_fifo[r_wr_ptr[ID_WIDTH-1:0]] <= w_arb_idx;
            r_wr_ptr <= r_wr_ptr + (ID_WIDTH+1)'(1);
            r_rr_ptr <= w_arb_idx + ID_WIDTH'(1);
         end
         if (w_fire) begin
            r_rd_ptr <= r_rd_ptr + (ID_WIDTH+1)'(1);
         end
      end
   end

`ifdef CORE_DISPATCHER_STATS_EN
   logic [31:0] r_acc_cnt;
   logic [31:0] r_rej_cnt;

   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         r_acc_cnt <= '0;
         r_rej_cnt <= '0;
      end else if (w_fire) begin
         if (vrd_acc == VRD_ACC) begin
            if (r_acc_cnt != 32'hFFFF_FFFF) r_acc_cnt <= r_acc_cnt + 32'd1;
         end else begin
            if (r_rej_cnt != 32'hFFFF_FFFF) r_rej_cnt <= r_rej_cnt + 32'd1;
         end
      end
   end

   assign acc_cnt = rst ? '0 : r_acc_cnt;
   assign rej_cnt = rst ? '0 : r_rej_cnt;
`endif

   a_ptr_sync: assert property (@(posedge clk) disable iff (rst)
      (r_wr_ptr - r_rd_ptr) == (ID_WIDTH+1)'(r_inflight));
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_gnt && !w_fire && r_inflight == CNT_WIDTH'(N_CORES)));

endmodule

// File: tb/tb_core_dispatcher.sv
// Directed bench for core_dispatcher: dispatch order, in-order retire,
// backpressure, simultaneous dispatch/retire and mid-operation reset.
module tb_core_dispatcher;

   logic       clk = 1'b0;
   logic       rst;
   logic       pkt_req;
   logic       pkt_gnt;
   logic [1:0] pkt_core;
   logic [3:0] core_idle;
   logic [3:0] core_start;
   logic [3:0] core_acc;
   logic [3:0] core_rej;
   logic [3:0] core_done_ack;
   logic       vrd_vld;
   logic       vrd_rdy;
   logic       vrd_acc;
   logic [1:0] vrd_core;
   logic [2:0] inflight;
`ifdef CORE_DISPATCHER_STATS_EN
   logic        stats_clr = 1'b0;
   logic [31:0] acc_cnt;
   logic [31:0] rej_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   core_dispatcher #(.N_CORES(4), .ID_WIDTH(2), .CNT_WIDTH(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .pkt_req       (pkt_req),
      .pkt_gnt       (pkt_gnt),
      .pkt_core      (pkt_core),
      .core_idle     (core_idle),
      .core_start    (core_start),
      .core_acc      (core_acc),
      .core_rej      (core_rej),
      .core_done_ack (core_done_ack),
      .vrd_vld       (vrd_vld),
      .vrd_rdy       (vrd_rdy),
      .vrd_acc       (vrd_acc),
      .vrd_core      (vrd_core),
`ifdef CORE_DISPATCHER_STATS_EN
      .stats_clr     (stats_clr),
      .acc_cnt       (acc_cnt),
      .rej_cnt       (rej_cnt),
`endif
      .inflight      (inflight)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; pkt_req = 1'b0; core_acc = '0; core_rej = '0;
      vrd_rdy = 1'b0; core_idle = 4'hF;
      step(); step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; pkt_req = 1'b1; core_idle = 4'hF; core_acc = 4'h1;
      core_rej = '0; vrd_rdy = 1'b1;
      step(); step();
      #1;
      n_total++; if (pkt_gnt !== 1'b0) $display("FAIL rst_gnt got=%b want=0", pkt_gnt); else n_pass++;
      n_total++; if (core_start !== 4'h0) $display("FAIL rst_start got=%b want=0000", core_start); else n_pass++;
      n_total++; if (vrd_vld !== 1'b0) $display("FAIL rst_vld got=%b want=0", vrd_vld); else n_pass++;
      n_total++; if (inflight !== 3'd0) $display("FAIL rst_inflight got=%0d want=0", inflight); else n_pass++;
      rst = 1'b0; pkt_req = 1'b0; core_acc = '0; vrd_rdy = 1'b0;
      step();
      n_total++; if (inflight !== 3'd0 || vrd_vld !== 1'b0 || core_done_ack !== 4'h0)
         $display("FAIL post_rst got inflight=%0d vld=%b ack=%b want 0/0/0000", inflight, vrd_vld, core_done_ack);
      else n_pass++;
      $display("reset: done");
   endtask

   task automatic test_single();
      do_reset();
      pkt_req = 1'b1;
      #1;
      n_total++; if (pkt_gnt !== 1'b1 || pkt_core !== 2'd0 || core_start !== 4'b0001)
         $display("FAIL single_gnt got gnt=%b core=%0d start=%b want 1/0/0001", pkt_gnt, pkt_core, core_start);
      else n_pass++;
      $display("dispatch: core %0d", pkt_core);
      step();
      pkt_req = 1'b0;
      #1;
      n_total++; if (inflight !== 3'd1) $display("FAIL single_inflight1 got=%0d want=1", inflight); else n_pass++;
      core_acc = 4'b0001; vrd_rdy = 1'b1;
      #1;
      n_total++; if (vrd_vld !== 1'b1 || vrd_acc !== 1'b1 || vrd_core !== 2'd0 || core_done_ack !== 4'b0001)
         $display("FAIL single_vrd got vld=%b acc=%b core=%0d ack=%b want 1/1/0/0001", vrd_vld, vrd_acc, vrd_core, core_done_ack);
      else n_pass++;
      $display("retire: core %0d acc=%b", vrd_core, vrd_acc);
      step();
      core_acc = '0;
      #1;
      n_total++; if (inflight !== 3'd0 || vrd_vld !== 1'b0)
         $display("FAIL single_retired got inflight=%0d vld=%b want 0/0", inflight, vrd_vld);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      do_reset();
      pkt_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_total++; if (pkt_gnt !== 1'b1 || pkt_core !== 2'(k))
            $display("FAIL rr_gnt%0d got gnt=%b core=%0d want 1/%0d", k, pkt_gnt, pkt_core, k);
         else n_pass++;
         $display("dispatch: core %0d", pkt_core);
         step();
      end
      #1;
      n_total++; if (pkt_gnt !== 1'b0 || inflight !== 3'd4)
         $display("FAIL rr_full got gnt=%b inflight=%0d want 0/4", pkt_gnt, inflight);
      else n_pass++;
      pkt_req = 1'b0;
   endtask

   task automatic test_in_order();
      do_reset();
      pkt_req = 1'b1;
      step(); step(); step();
      pkt_req = 1'b0;
      core_rej = 4'b0100; core_acc = 4'b0010; vrd_rdy = 1'b1;
      #1;
      n_total++; if (vrd_vld !== 1'b0 || core_done_ack !== 4'h0)
         $display("FAIL order_hold got vld=%b ack=%b want 0/0000", vrd_vld, core_done_ack);
      else n_pass++;
      step();
      n_total++; if (vrd_vld !== 1'b0 || inflight !== 3'd3)
         $display("FAIL order_hold2 got vld=%b inflight=%0d want 0/3", vrd_vld, inflight);
      else n_pass++;
      core_acc = 4'b0011;
      #1;
      n_total++; if (vrd_vld !== 1'b1 || vrd_core !== 2'd0 || vrd_acc !== 1'b1 || core_done_ack !== 4'b0001)
         $display("FAIL order_v0 got vld=%b core=%0d acc=%b ack=%b want 1/0/1/0001", vrd_vld, vrd_core, vrd_acc, core_done_ack);
      else n_pass++;
      $display("retire: core %0d acc=%b", vrd_core, vrd_acc);
      step();
      core_acc = 4'b0010;
      #1;
      n_total++; if (vrd_vld !== 1'b1 || vrd_core !== 2'd1 || vrd_acc !== 1'b1 || core_done_ack !== 4'b0010)
         $display("FAIL order_v1 got vld=%b core=%0d acc=%b ack=%b want 1/1/1/0010", vrd_vld, vrd_core, vrd_acc, core_done_ack);
      else n_pass++;
      $display("retire: core %0d acc=%b", vrd_core, vrd_acc);
      step();
      core_acc = 4'b0000;
      #1;
      n_total++; if (vrd_vld !== 1'b1 || vrd_core !== 2'd2 || vrd_acc !== 1'b0 || core_done_ack !== 4'b0100)
         $display("FAIL order_v2 got vld=%b core=%0d acc=%b ack=%b want 1/2/0/0100", vrd_vld, vrd_core, vrd_acc, core_done_ack);
      else n_pass++;
      $display("retire: core %0d acc=%b", vrd_core, vrd_acc);
      step();
      core_rej = '0;
      #1;
      n_total++; if (inflight !== 3'd0 || vrd_vld !== 1'b0)
         $display("FAIL order_end got inflight=%0d vld=%b want 0/0", inflight, vrd_vld);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      do_reset();
      pkt_req = 1'b1;
      step();
      pkt_req = 1'b0; core_acc = 4'b0001; vrd_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_total++; if (vrd_vld !== 1'b1 || vrd_core !== 2'd0 || vrd_acc !== 1'b1 || core_done_ack !== 4'h0)
            $display("FAIL bp_stall%0d got vld=%b core=%0d acc=%b ack=%b want 1/0/1/0000", k, vrd_vld, vrd_core, vrd_acc, core_done_ack);
         else n_pass++;
         step();
      end
      vrd_rdy = 1'b1;
      #1;
      n_total++; if (core_done_ack !== 4'b0001) $display("FAIL bp_ack got=%b want=0001", core_done_ack); else n_pass++;
      $display("retire: core %0d acc=%b after stall", vrd_core, vrd_acc);
      step();
      core_acc = '0;
      #1;
      n_total++; if (core_done_ack !== 4'h0 || inflight !== 3'd0)
         $display("FAIL bp_single got ack=%b inflight=%0d want 0000/0", core_done_ack, inflight);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      do_reset();
      pkt_req = 1'b1;
      step(); step(); step(); step();
      core_acc = 4'b0001; core_rej = 4'b0001; vrd_rdy = 1'b1;
      #1;
      n_total++; if (pkt_gnt !== 1'b0 || vrd_vld !== 1'b1 || vrd_acc !== 1'b0 || core_done_ack !== 4'b0001 || inflight !== 3'd4)
         $display("FAIL sim_fire got gnt=%b vld=%b acc=%b ack=%b inflight=%0d want 0/1/0/0001/4",
                  pkt_gnt, vrd_vld, vrd_acc, core_done_ack, inflight);
      else n_pass++;
      $display("retire: core %0d acc=%b (both verdicts)", vrd_core, vrd_acc);
      step();
      core_acc = '0; core_rej = '0;
      #1;
      n_total++; if (pkt_gnt !== 1'b1 || pkt_core !== 2'd0 || inflight !== 3'd3)
         $display("FAIL sim_regrant got gnt=%b core=%0d inflight=%0d want 1/0/3", pkt_gnt, pkt_core, inflight);
      else n_pass++;
      $display("dispatch: core %0d", pkt_core);
      step();
      pkt_req = 1'b0;
      #1;
      n_total++; if (inflight !== 3'd4) $display("FAIL sim_inflight got=%0d want=4", inflight); else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      pkt_req = 1'b1;
      step(); step(); step();
      pkt_req = 1'b0; core_acc = 4'b0001; vrd_rdy = 1'b0;
      #1;
      n_total++; if (inflight !== 3'd3 || vrd_vld !== 1'b1)
         $display("FAIL mid_pre got inflight=%0d vld=%b want 3/1", inflight, vrd_vld);
      else n_pass++;
      rst = 1'b1; vrd_rdy = 1'b1;
      #1;
      n_total++; if (vrd_vld !== 1'b0 || core_done_ack !== 4'h0 || inflight !== 3'd0)
         $display("FAIL mid_rst got vld=%b ack=%b inflight=%0d want 0/0000/0", vrd_vld, core_done_ack, inflight);
      else n_pass++;
      step();
      rst = 1'b0; core_acc = '0;
      step();
      n_total++; if (vrd_vld !== 1'b0 || inflight !== 3'd0)
         $display("FAIL mid_after got vld=%b inflight=%0d want 0/0", vrd_vld, inflight);
      else n_pass++;
      pkt_req = 1'b1;
      #1;
      n_total++; if (pkt_gnt !== 1'b1 || pkt_core !== 2'd0)
         $display("FAIL mid_regrant got gnt=%b core=%0d want 1/0", pkt_gnt, pkt_core);
      else n_pass++;
      $display("dispatch: core %0d after reset", pkt_core);
      step();
      pkt_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_in_order();
      test_backpressure();
      test_simultaneous();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/core_dispatcher.md
Name: core_dispatcher

Overview:
- Shares the incoming packet stream among N_CORES parallel packet-filter cores (buffer + bpfcpu pairs).
- Assigns each new packet to an idle core by round-robin and records the assignment order in a tag FIFO.
- Retires verdicts (accept/reject) strictly in dispatch order, so the downstream forwarder sees packets in arrival order.
- Generates each core's done-acknowledge pulse.

Parameters:
- N_CORES, 4, number of cores; power of two, 2..16
- ID_WIDTH, 2, width of core index; equals log2(N_CORES)
- CNT_WIDTH, 3, width of in-flight count; equals ID_WIDTH+1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pkt_req  in  1  upstream snooper has a packet ready to dispatch
- pkt_gnt  out  1  dispatch fires this cycle
- pkt_core  out  ID_WIDTH  index of granted core; valid when pkt_gnt
- core_idle  in  N_CORES  per-core "ready to accept packet"
- core_start  out  N_CORES  one-hot start pulse, equals pkt_gnt decoded
- core_acc  in  N_CORES  per-core accept verdict, level until acked
- core_rej  in  N_CORES  per-core reject verdict, level until acked
- core_done_ack  out  N_CORES  one-hot verdict acknowledge pulse
- vrd_vld  out  1  verdict valid
- vrd_rdy  in  1  downstream accepts verdict
- vrd_acc  out  1  1 = accept, 0 = reject
- vrd_core  out  ID_WIDTH  core that produced the verdict
- inflight  out  CNT_WIDTH  number of dispatched, unretired packets

Behaviour:
- Reset: clk/rst are a synchronous, active-high reset and clock.
  - On reset: rr pointer=0, tag FIFO empty, busy mask=0, inflight=0.
  - All outputs are 0 while rst is high and in the first cycle after it.
  - Reset mid-operation drops all in-flight tags without issuing acks; cores are reset by their own rst.
- Eligibility: eligible[i] = core_idle[i] & ~busy[i].
- Dispatch is combinational:
  - pkt_gnt = pkt_req & |eligible & ~rst.
  - Grant goes to the first eligible index at or after rr_ptr, wrapping modulo N_CORES.
  - On pkt_gnt, at the clock edge: busy[g] set; g pushed to the FIFO; rr_ptr set to (g+1) mod N_CORES.
  - The FIFO cannot overflow because busy limits in-flight packets to N_CORES (depth = N_CORES).
- Retire:
  - h = FIFO head.
  - vrd_vld = ~empty & (core_acc[h] | core_rej[h]).
  - vrd_acc = core_acc[h] & ~core_rej[h]; if both are high, reject wins.
  - vrd_core = h.
  - Verdicts from non-head cores are held (not acked) until they reach the head.
  - vrd_vld/vrd_acc/vrd_core hold stable while vrd_vld & ~vrd_rdy.
  - Fire = vrd_vld & vrd_rdy. On fire: core_done_ack[h]=1 in the same cycle (combinational); at the edge, pop the FIFO and clear busy[h].
- Simultaneous events:
  - Dispatch and retire in the same cycle are allowed; inflight is unchanged.
  - A core retired in cycle t is not eligible until t+1 (busy clears at the edge).
  - Push and pop in the same cycle on a full FIFO is legal only with a pop, which cannot occur since the granted core is non-busy.
- Latency:
  - pkt_req to pkt_gnt: 0 cycles.
  - Head verdict to vrd_vld: 0 cycles.
  - Fire to next head verdict visible: 1 cycle.
- Wrap-around: FIFO pointers are ID_WIDTH bits plus a wrap bit; full/empty are derived from inflight.

Optional Feature:
- Macro: CORE_DISPATCHER_STATS_EN.
- When defined, adds outputs acc_cnt[31:0] and rej_cnt[31:0] plus input stats_clr.
  - Counters increment on fire according to vrd_acc, saturate at 0xFFFFFFFF, and clear on rst or stats_clr.
  - stats_clr wins over a simultaneous increment.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package core_dispatcher_pkg holds:
  - derived-width constants (ID_WIDTH, CNT_WIDTH from N_CORES)
  - the verdict-encoding constants VRD_ACC=1, VRD_REJ=0
- One natural sub-module, rr_arbiter: combinational N-way round-robin priority pick from request vector plus pointer, producing one-hot grant and index.
- The tag FIFO stays inline.

Test Plan:
- Single packet: all cores idle, rr_ptr=0, pkt_req 1 cycle -> pkt_gnt=1, pkt_core=0, core_start=4'b0001. Then core_acc[0]=1 with vrd_rdy=1 -> vrd_vld=1, vrd_acc=1, vrd_core=0, core_done_ack=4'b0001, inflight 1->0.
- Round-robin: pkt_req held high with all cores idle -> grants 0,1,2,3 on consecutive cycles, then pkt_gnt=0 with inflight=4.
- In-order retire: cores 0,1,2 dispatched; core_rej[2] and core_acc[1] raised first -> no vrd_vld and no acks. Then core_acc[0] raised -> verdicts emitted in order core 0 (acc), core 1 (acc), core 2 (rej) on three consecutive fires.
- Backpressure: head verdict present, vrd_rdy=0 for 5 cycles -> vrd_* stable and core_done_ack=0 throughout; vrd_rdy=1 -> single ack pulse.
- Simultaneous event: 4 in flight, head core 0 fires while pkt_req=1 -> no grant that cycle (core 0 still busy); next cycle grant core 0, inflight stays 4. Both acc and rej on the head -> vrd_acc=0.
- Reset mid-operation: 3 in flight, rst pulse -> inflight=0, vrd_vld=0, no acks issued, next grant is core 0.
